axi_arbiter_2x1: RTL
====================

AXI_ARBITER_2X1 -- requirements
Module: axi_arbiter_2x1

Interface
REQ-001 SHALL have CLK, input, 1: system clock; all logic on posedge.
REQ-002 SHALL have RST, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have S0_AXI_AR{ADDR,LEN,SIZE,BURST,VALID}, input, 32/8/3/2/1: requester 0 (instruction cache) read-address channel.
REQ-004 SHALL have S0_AXI_ARREADY, output, 1: requester 0 read-address accept.
REQ-005 SHALL have S0_AXI_R{ID,DATA,RESP,LAST,VALID}, output, 1/32/2/1/1: requester 0 read-data channel.
REQ-006 SHALL have S0_AXI_AW{ADDR,LEN,SIZE,BURST,VALID}, input, 32/8/3/2/1, and S0_AXI_AWREADY, output, 1: requester 0 write-address channel.
REQ-007 SHALL have S0_AXI_W{DATA,STRB,LAST,VALID}, input, 32/4/1/1, and S0_AXI_WREADY, output, 1: requester 0 write-data channel.
REQ-008 SHALL have S0_AXI_B{ID,RESP,VALID}, output, 1/2/1: requester 0 write-response channel.
REQ-009 SHALL have S1_AXI_* ports identical to REQ-003..REQ-008: requester 1 (data cache).
REQ-010 SHALL have M_AXI_* ports, mirror directions of REQ-003..REQ-008: shared downstream AXI master.
REQ-011 SHALL have RGRANT and WGRANT, output, 2 each: one-hot current read/write owner; 2'b00 when idle.

Function
REQ-012 Read path and write path SHALL arbitrate independently; each has FSM states IDLE, OWN0, OWN1.
REQ-013 Read FSM IDLE->OWNn SHALL occur on the cycle after Sn_AXI_ARVALID is sampled high; the grant is registered, giving 1 cycle added latency to ARVALID.
REQ-014 Read FSM OWNn->IDLE SHALL occur on the cycle after M_AXI_RVALID && M_AXI_RLAST; the next grant is never taken in that same cycle, so at least one IDLE cycle always separates bursts.
REQ-015 Write FSM IDLE->OWNn SHALL occur on the cycle after Sn_AXI_AWVALID is sampled high; OWNn->IDLE on the cycle after M_AXI_BVALID.
REQ-016 While OWNn, M_AXI AR/AW/W request fields SHALL be combinationally driven from requester n.
REQ-017 While OWNn, M_AXI_ARREADY/AWREADY/WREADY and the R/B channels SHALL be routed to requester n only; the other requester sees all VALID/READY = 0.
REQ-018 In IDLE, M_AXI_ARVALID/AWVALID/WVALID SHALL be 0, all S*_READY SHALL be 0, and all M_AXI_* request fields SHALL be 0.
REQ-019 A grant SHALL be held across the whole burst, including AR/AW wait cycles; ownership never changes mid-burst.
REQ-020 Simultaneous requests SHALL resolve per REQ-026/REQ-027.
REQ-021 R or B beats arriving while IDLE SHALL be dropped and not forwarded to either requester.
REQ-022 Read owner and write owner MAY differ at the same time; no ordering is enforced between read and write paths.

Reset
REQ-023 On RST, both FSMs SHALL go to IDLE, RGRANT = WGRANT = 2'b00, and priority state SHALL point to requester 0.
REQ-024 RST during a burst SHALL abandon it immediately; outputs take REQ-018 values on the next cycle, and no further beats are forwarded.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN SHALL select the priority scheme.
REQ-026 With ARB_ROUND_ROBIN_EN defined, each path SHALL keep a 1-bit last-owner register updated on entry to OWNn; on simultaneous requests, the requester other than the last owner wins.
REQ-027 With ARB_ROUND_ROBIN_EN undefined, requester 0 SHALL always win simultaneous requests; no last-owner register is instantiated.

Verification
REQ-028 Single read: S1 ARVALID, ARADDR=0x0000_2000, LEN=0x1f; 32 RVALID beats with RLAST on beat 32 -> RGRANT=2'b10 one cycle later; 32 beats delivered to S1 only; RGRANT=2'b00 the cycle after RLAST.
REQ-029 Contention, fixed priority: S0 and S1 ARVALID in the same cycle -> S0 burst completes first, then one IDLE cycle, then S1 is granted.
REQ-030 Contention, round robin (macro defined): two back-to-back simultaneous request pairs -> grant order S0, S1, S0, S1.
REQ-031 Parallel paths: S0 reads 0x1000 while S1 writes 32 words to 0x3000 -> RGRANT=01 and WGRANT=10 concurrently; WLAST on word 32; BVALID routed to S1; data intact.
REQ-032 RST asserted after the 10th R beat -> next cycle RGRANT=00 and M_AXI_ARVALID=0; remaining beats are not forwarded; a new S0 request is granted normally.

Source files
------------

// File: rtl/axi_arbiter_2x1_if.sv
// One AXI read/write port bundle (AR, R, AW, W, B) with no R/B ready signals.
// The master modport issues requests; the slave modport accepts them and returns responses.
interface axi_arbiter_2x1_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic        rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic        bid;
  logic [1:0]  bresp;
  logic        bvalid;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_arbiter_2x1.sv
// Two-requester AXI arbiter with independent read and write ownership FSMs.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; the default is fixed priority to requester 0.
//
// state | meaning
// IDLE  | no owner; request fields zeroed; R/B beats dropped
// OWN0  | requester 0 owns the path until RLAST beat (read) or BVALID (write)
// OWN1  | requester 1 owns the path until RLAST beat (read) or BVALID (write)
module axi_arbiter_2x1 (
  input  logic              CLK,
  input  logic              RST,
  axi_arbiter_2x1_if.slave  s0_axi,
  axi_arbiter_2x1_if.slave  s1_axi,
  axi_arbiter_2x1_if.master m_axi,
  output logic [1:0]        RGRANT,
  output logic [1:0]        WGRANT
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_state_t;

  own_state_t rd_state, rd_next;
  own_state_t wr_state, wr_next;
  logic       rd_pick1;
  logic       wr_pick1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_state <= IDLE;
      wr_state <= IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last owner resets to 1 so requester 0 wins the first contention.
  logic rd_last_r;
  logic wr_last_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_last_r <= 1'b1;
      wr_last_r <= 1'b1;
    end else begin
      if (rd_state == IDLE && rd_next == OWN0) rd_last_r <= 1'b0;
      else if (rd_state == IDLE && rd_next == OWN1) rd_last_r <= 1'b1;
      if (wr_state == IDLE && wr_next == OWN0) wr_last_r <= 1'b0;
      else if (wr_state == IDLE && wr_next == OWN1) wr_last_r <= 1'b1;
    end
  end

  assign rd_pick1 = ~rd_last_r;
  assign wr_pick1 = ~wr_last_r;
`else
  assign rd_pick1 = 1'b0;
  assign wr_pick1 = 1'b0;
`endif

  assign RGRANT = {rd_state == OWN1, rd_state == OWN0};
  assign WGRANT = {wr_state == OWN1, wr_state == OWN0};

  // Read path: next state plus AR/R routing.
  always_comb begin
    rd_next          = rd_state;
    m_axi.araddr     = '0;
    m_axi.arlen      = '0;
    m_axi.arsize     = '0;
    m_axi.arburst    = '0;
    m_axi.arvalid    = 1'b0;
    s0_axi.arready   = 1'b0;
    s0_axi.rid       = 1'b0;
    s0_axi.rdata     = '0;
    s0_axi.rresp     = '0;
    s0_axi.rlast     = 1'b0;
    s0_axi.rvalid    = 1'b0;
    s1_axi.arready   = 1'b0;
    s1_axi.rid       = 1'b0;
    s1_axi.rdata     = '0;
    s1_axi.rresp     = '0;
    s1_axi.rlast     = 1'b0;
    s1_axi.rvalid    = 1'b0;
    case (rd_state)
      IDLE: begin
        if (s0_axi.arvalid && s1_axi.arvalid) rd_next = rd_pick1 ? OWN1 : OWN0;
        else if (s0_axi.arvalid)              rd_next = OWN0;
        else if (s1_axi.arvalid)              rd_next = OWN1;
      end
      OWN0: begin
        m_axi.araddr   = s0_axi.araddr;
        m_axi.arlen    = s0_axi.arlen;
        m_axi.arsize   = s0_axi.arsize;
        m_axi.arburst  = s0_axi.arburst;
        m_axi.arvalid  = s0_axi.arvalid;
        s0_axi.arready = m_axi.arready;
        s0_axi.rid     = m_axi.rid;
        s0_axi.rdata   = m_axi.rdata;
        s0_axi.rresp   = m_axi.rresp;
        s0_axi.rlast   = m_axi.rlast;
        s0_axi.rvalid  = m_axi.rvalid;
        if (m_axi.rvalid && m_axi.rlast) rd_next = IDLE;
      end
      OWN1: begin
        m_axi.araddr   = s1_axi.araddr;
        m_axi.arlen    = s1_axi.arlen;
        m_axi.arsize   = s1_axi.arsize;
        m_axi.arburst  = s1_axi.arburst;
        m_axi.arvalid  = s1_axi.arvalid;
        s1_axi.arready = m_axi.arready;
        s1_axi.rid     = m_axi.rid;
        s1_axi.rdata   = m_axi.rdata;
        s1_axi.rresp   = m_axi.rresp;
        s1_axi.rlast   = m_axi.rlast;
        s1_axi.rvalid  = m_axi.rvalid;
        if (m_axi.rvalid && m_axi.rlast) rd_next = IDLE;
      end
      default: rd_next = IDLE;
    endcase
  end

  // Write path: next state plus AW/W/B routing.
  always_comb begin
    wr_next          = wr_state;
    m_axi.awaddr     = '0;
    m_axi.awlen      = '0;
    m_axi.awsize     = '0;
    m_axi.awburst    = '0;
    m_axi.awvalid    = 1'b0;
    m_axi.wdata      = '0;
    m_axi.wstrb      = '0;
    m_axi.wlast      = 1'b0;
    m_axi.wvalid     = 1'b0;
    s0_axi.awready   = 1'b0;
    s0_axi.wready    = 1'b0;
    s0_axi.bid       = 1'b0;
    s0_axi.bresp     = '0;
    s0_axi.bvalid    = 1'b0;
    s1_axi.awready   = 1'b0;
    s1_axi.wready    = 1'b0;
    s1_axi.bid       = 1'b0;
    s1_axi.bresp     = '0;
    s1_axi.bvalid    = 1'b0;
    case (wr_state)
      IDLE: begin
        if (s0_axi.awvalid && s1_axi.awvalid) wr_next = wr_pick1 ? OWN1 : OWN0;
        else if (s0_axi.awvalid)              wr_next = OWN0;
        else if (s1_axi.awvalid)              wr_next = OWN1;
      end
      OWN0: begin
        m_axi.awaddr   = s0_axi.awaddr;
        m_axi.awlen    = s0_axi.awlen;
        m_axi.awsize   = s0_axi.awsize;
        m_axi.awburst  = s0_axi.awburst;
        m_axi.awvalid  = s0_axi.awvalid;
        m_axi.wdata    = s0_axi.wdata;
        m_axi.wstrb    = s0_axi.wstrb;
        m_axi.wlast    = s0_axi.wlast;
        m_axi.wvalid   = s0_axi.wvalid;
        s0_axi.awready = m_axi.awready;
        s0_axi.wready  = m_axi.wready;
        s0_axi.bid     = m_axi.bid;
        s0_axi.bresp   = m_axi.bresp;
        s0_axi.bvalid  = m_axi.bvalid;
        if (m_axi.bvalid) wr_next = IDLE;
      end
      OWN1: begin
        m_axi.awaddr   = s1_axi.awaddr;
        m_axi.awlen    = s1_axi.awlen;
        m_axi.awsize   = s1_axi.awsize;
        m_axi.awburst  = s1_axi.awburst;
        m_axi.awvalid  = s1_axi.awvalid;
        m_axi.wdata    = s1_axi.wdata;
        m_axi.wstrb    = s1_axi.wstrb;
        m_axi.wlast    = s1_axi.wlast;
        m_axi.wvalid   = s1_axi.wvalid;
        s1_axi.awready = m_axi.awready;
        s1_axi.wready  = m_axi.wready;
        s1_axi.bid     = m_axi.bid;
        s1_axi.bresp   = m_axi.bresp;
        s1_axi.bvalid  = m_axi.bvalid;
        if (m_axi.bvalid) wr_next = IDLE;
      end
      default: wr_next = IDLE;
    endcase
  end

endmodule
